// File: rtl/r_to_p_sm.sv
// Rectangular-to-polar converter: iterative CORDIC in vectoring mode, one
// micro-rotation per clock, returning magnitude and binary angle with a done pulse.
module r_to_p_sm #(
    parameter int ITERS = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [15:0] X_in,
    input  logic [15:0] Y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] Mag_out,
    output logic [15:0] Angle_out
);

    typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        x_lat;
    logic [15:0]        y_lat;
    logic signed [17:0] x_ext;
    logic signed [17:0] y_ext;
    logic signed [17:0] x_r;
    logic signed [17:0] y_r;
    logic signed [17:0] x_sh;
    logic signed [17:0] y_sh;
    logic [15:0]        z_r;
    logic [3:0]         iter_cnt;
    logic               accept;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'd8192;
            4'd1:    atan_lut = 16'd4836;
            4'd2:    atan_lut = 16'd2555;
            4'd3:    atan_lut = 16'd1297;
            4'd4:    atan_lut = 16'd651;
            4'd5:    atan_lut = 16'd326;
            4'd6:    atan_lut = 16'd163;
            4'd7:    atan_lut = 16'd81;
            4'd8:    atan_lut = 16'd41;
            4'd9:    atan_lut = 16'd20;
            4'd10:   atan_lut = 16'd10;
            4'd11:   atan_lut = 16'd5;
            4'd12:   atan_lut = 16'd3;
            4'd13:   atan_lut = 16'd1;
            4'd14:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign x_ext  = $signed({{2{x_lat[15]}}, x_lat});
    assign y_ext  = $signed({{2{y_lat[15]}}, y_lat});
    assign x_sh   = x_r >>> iter_cnt;
    assign y_sh   = y_r >>> iter_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = PRE;
            end
            PRE: begin
                busy      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (iter_cnt == LAST_ITER) state_nxt = SCALE;
            end
            SCALE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? PRE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Left-half-plane inputs are rotated by 180 degrees first so vectoring always starts with x >= 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_lat     <= '0;
            y_lat     <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            iter_cnt  <= '0;
            Mag_out   <= '0;
            Angle_out <= '0;
        end else begin
            if (accept) begin
                x_lat <= X_in;
                y_lat <= Y_in;
            end
            case (state)
                PRE: begin
                    if (x_lat[15]) begin
                        x_r <= -x_ext;
                        y_r <= -y_ext;
                        z_r <= 16'h8000;
                    end else begin
                        x_r <= x_ext;
                        y_r <= y_ext;
                        z_r <= 16'h0000;
                    end
                    iter_cnt <= '0;
                end
                ITER: begin
                    if (!y_r[17]) begin
                        x_r <= x_r + y_sh;
                        y_r <= y_r - x_sh;
                        z_r <= z_r + atan_lut(iter_cnt);
                    end else begin
                        x_r <= x_r - y_sh;
                        y_r <= y_r + x_sh;
                        z_r <= z_r - atan_lut(iter_cnt);
                    end
                    iter_cnt <= iter_cnt + 4'd1;
                end
                SCALE: begin
                    // 39797/65536 undoes the CORDIC gain; x is never negative here.
                    if ((x_lat == 16'd0) && (y_lat == 16'd0)) begin
                        Mag_out   <= '0;
                        Angle_out <= '0;
                    end else begin
                        Mag_out   <= 16'(({16'b0, x_r} * 34'd39797 + 34'd32768) >> 16);
                        Angle_out <= z_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
